// File: rtl/cache_assoc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cache_assoc : N-way set-associative write-through data cache, one-word lines
// Revision 1.0
// ----------------------------------------------------------------------------
module cache_assoc #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int WAYS       = 2,
  parameter int SETS       = 128,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    hit,
  output logic                    miss,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_write,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic [CNT_WIDTH-1:0]    hit_count,
  output logic [CNT_WIDTH-1:0]    miss_count
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W    = $clog2(SETS);
  localparam int TAG_W    = ADDR_WIDTH - IDX_W - 2;
  localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_REQ  = 2'd1;
  localparam logic [1:0] RD_WAIT = 2'd2;
  localparam logic [1:0] WR_REQ  = 2'd3;

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] data_mem [WAYS][SETS];
  logic [TAG_W-1:0]      tag_mem  [WAYS][SETS];
  logic [WAYS-1:0]       valid    [SETS];
  logic [WAY_W-1:0]      ptr      [SETS];

  logic [TAG_W-1:0]      lat_tag;
  logic [IDX_W-1:0]      lat_idx;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [BE_WIDTH-1:0]   lat_be;
  logic                  lat_hit;

  logic [IDX_W-1:0]      req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic                  any_hit;
  logic [WAY_W-1:0]      hit_way;
  logic [DATA_WIDTH-1:0] hit_data;
  logic [DATA_WIDTH-1:0] merged;
  logic [WAY_W-1:0]      victim;
  logic                  victim_is_ptr;
  logic                  accept;
  logic                  fill;
  logic                  unused_addr_bits;

  assign req_idx          = req_addr[IDX_W+1:2];
  assign req_tag          = req_addr[ADDR_WIDTH-1:IDX_W+2];
  assign unused_addr_bits = ^req_addr[1:0];

  assign req_ready = reset && (state == IDLE) && !flush;
  assign accept    = req_valid && req_ready;
  assign fill      = (state == RD_WAIT) && mem_resp_valid;

  assign mem_req_valid = (state == RD_REQ) || (state == WR_REQ);
  assign mem_req_write = (state == WR_REQ);
  assign mem_addr      = {lat_tag, lat_idx, 2'b00};
  assign mem_wdata     = lat_wdata;
  assign mem_be        = (state == RD_REQ) ? {BE_WIDTH{1'b1}} : lat_be;

  always_comb begin
    any_hit  = 1'b0;
    hit_way  = '0;
    hit_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!any_hit && valid[req_idx][w] && (tag_mem[w][req_idx] == req_tag)) begin
        any_hit  = 1'b1;
        hit_way  = WAY_W'(w);
        hit_data = data_mem[w][req_idx];
      end
    end
  end

  always_comb begin
    merged = hit_data;
    for (int b = 0; b < BE_WIDTH; b++) begin
      if (req_be[b]) merged[b*8 +: 8] = req_wdata[b*8 +: 8];
    end
  end

  // Invalid ways are filled first (lowest index wins); the pointer only decides when the set is full.
  always_comb begin
    victim        = ptr[lat_idx];
    victim_is_ptr = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[lat_idx][w]) begin
        victim        = WAY_W'(w);
        victim_is_ptr = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      data_mem[victim][lat_idx] <= mem_rdata;
      tag_mem[victim][lat_idx]  <= lat_tag;
    end else if (accept && req_write && any_hit) begin
      data_mem[hit_way][req_idx] <= merged;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        ptr[s]   <= '0;
      end
      lat_tag    <= '0;
      lat_idx    <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      lat_hit    <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      hit        <= 1'b0;
      miss       <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      resp_valid <= 1'b0;
      hit        <= 1'b0;
      miss       <= 1'b0;
      case (state)
        IDLE: begin
          if (flush) begin
            for (int s = 0; s < SETS; s++) valid[s] <= '0;
          end else if (req_valid) begin
            lat_tag   <= req_tag;
            lat_idx   <= req_idx;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
            lat_hit   <= any_hit;
            if (req_write) begin
              state <= WR_REQ;
              if (!any_hit && !(&miss_count)) miss_count <= miss_count + CNT_WIDTH'(1);
            end else if (any_hit) begin
              resp_valid <= 1'b1;
              hit        <= 1'b1;
              resp_rdata <= hit_data;
              if (!(&hit_count)) hit_count <= hit_count + CNT_WIDTH'(1);
            end else begin
              state <= RD_REQ;
              if (!(&miss_count)) miss_count <= miss_count + CNT_WIDTH'(1);
            end
          end
        end
        RD_REQ: begin
          if (mem_req_ready) state <= RD_WAIT;
        end
        RD_WAIT: begin
          if (mem_resp_valid) begin
            valid[lat_idx][victim] <= 1'b1;
            if (victim_is_ptr) begin
              ptr[lat_idx] <= (ptr[lat_idx] == WAY_W'(WAYS - 1)) ? '0
                                                                  : ptr[lat_idx] + WAY_W'(1);
            end
            resp_valid <= 1'b1;
            miss       <= 1'b1;
            resp_rdata <= mem_rdata;
            state      <= IDLE;
          end
        end
        WR_REQ: begin
          if (mem_req_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b1;
            hit        <= lat_hit;
            miss       <= !lat_hit;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_assoc.sv
`default_nettype none
// tb_cache_assoc : randomized self-checking bench for cache_assoc against a
// set/way/pointer reference model and a word-addressed backing memory.
module tb_cache_assoc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, req_valid, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        req_ready, resp_valid, hit, miss;
  logic [31:0] resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_req_write, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic [31:0] hit_count, miss_count;

  always #5 clk = ~clk;

  cache_assoc dut (
    .clk(clk), .reset(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .hit(hit), .miss(miss),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: 128 sets x 2 ways of tags, round-robin pointer per set,
  // plus backing memory. Being write-through, any read returns memory's word.
  bit          mval [128][2];
  logic [22:0] mtag [128][2];
  int          mptr [128];
  int          exp_hc = 0;
  int          exp_mc = 0;
  logic [31:0] bmem [int unsigned];
  logic [31:0] last_rdata = '0;

  typedef struct packed {
    logic        got;
    logic [31:0] rdata;
    logic        hit;
    logic        miss;
    int          lat;
    int          nreq;
    int          vcycles;
    logic        mwrite;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [3:0]  mbe;
    logic        unstable;
    logic        ready_bad;
    logic        extra;
  } obs_t;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    int unsigned k = a >> 2;
    if (!bmem.exists(k)) bmem[k] = $urandom;
    return bmem[k];
  endfunction

  function automatic void mem_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] cur = mem_word(a);
    for (int b = 0; b < 4; b++) if (be[b]) cur[b*8 +: 8] = d[b*8 +: 8];
    bmem[a >> 2] = cur;
  endfunction

  function automatic void model_clear(input bit full_reset);
    for (int s = 0; s < 128; s++) begin
      mval[s][0] = 1'b0;
      mval[s][1] = 1'b0;
      if (full_reset) mptr[s] = 0;
    end
  endfunction

  // Returns whether the access hits; applies allocation and counter effects.
  function automatic bit model_access(input bit wr, input logic [31:0] a);
    int s = int'(a[8:2]);
    logic [22:0] t = a[31:9];
    int v = -1;
    bit h = 1'b0;
    for (int w = 0; w < 2; w++) if (mval[s][w] && mtag[s][w] == t) h = 1'b1;
    if (wr) begin
      if (!h) exp_mc++;
      return h;
    end
    if (h) begin
      exp_hc++;
      return 1'b1;
    end
    exp_mc++;
    for (int w = 0; w < 2; w++) if (!mval[s][w] && v < 0) v = w;
    if (v < 0) begin
      v = mptr[s];
      mptr[s] = (mptr[s] + 1) % 2;
    end
    mval[s][v] = 1'b1;
    mtag[s][v] = t;
    return 1'b0;
  endfunction

  // Issues one request and plays backing memory; reports what was observed.
  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input int rdy_dly, input int resp_dly,
                        output obs_t o);
    int cyc = 0;
    int wait_rdy = 0;
    int wait_resp = 0;
    bit pend = 1'b0;
    bit hs = 1'b0;
    bit sent = 1'b0;
    o = '0;
    while (!req_ready && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_be = be;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 0;
    while (cyc < 100) begin
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      if (resp_valid) begin
        o.got = 1'b1; o.rdata = resp_rdata; o.hit = hit; o.miss = miss; o.lat = cyc;
        break;
      end
      if (req_ready) o.ready_bad = 1'b1;
      if (mem_req_valid) begin
        if (hs) o.extra = 1'b1;
        if (o.vcycles == 0) begin
          o.mwrite = mem_req_write; o.maddr = mem_addr; o.mwdata = mem_wdata; o.mbe = mem_be;
        end else if (o.mwrite !== mem_req_write || o.maddr !== mem_addr ||
                     o.mwdata !== mem_wdata || o.mbe !== mem_be) begin
          o.unstable = 1'b1;
        end
        o.vcycles++;
        if (wait_rdy >= rdy_dly) begin
          mem_req_ready = 1'b1;
          pend = 1'b1;
        end else wait_rdy++;
      end else if (hs && !sent && !o.mwrite) begin
        if (wait_resp >= resp_dly) begin
          mem_resp_valid = 1'b1;
          mem_rdata = mem_word(o.maddr);
          sent = 1'b1;
        end else wait_resp++;
      end
      @(posedge clk); #1; cyc++;
      if (pend) begin
        hs = 1'b1; o.nreq++; pend = 1'b0;
      end
    end
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 0; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    req_be = '0; mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
    #1;
    n_chk++; if (req_ready !== 1'b0 || resp_valid !== 1'b0 || mem_req_valid !== 1'b0)
      $display("FAIL reset_outputs: ready=%b resp=%b memv=%b want 0 0 0", req_ready, resp_valid, mem_req_valid);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1; #1;
    n_chk++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready); else n_pass++;
    n_chk++; if (hit_count !== 0 || miss_count !== 0)
      $display("FAIL reset_counters: got %0d/%0d want 0/0", hit_count, miss_count);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_read_miss_hit();
    obs_t o;
    bit h;
    bmem[32'h100 >> 2] = 32'hDEADBEEF;
    h = model_access(1'b0, 32'h100);
    do_req(1'b0, 32'h100, '0, 4'h0, 0, 3, o);
    n_chk++; if (!o.got || o.miss !== 1'b1 || o.hit !== 1'b0 || o.rdata !== 32'hDEADBEEF)
      $display("FAIL rd_miss: got=%b miss=%b hit=%b data=%h want 1 1 0 deadbeef", o.got, o.miss, o.hit, o.rdata);
    else n_pass++;
    n_chk++; if (o.nreq !== 1 || o.maddr !== 32'h100 || o.mwrite !== 1'b0 || o.mbe !== 4'hF)
      $display("FAIL rd_miss_mem: n=%0d addr=%h wr=%b be=%h want 1 100 0 f", o.nreq, o.maddr, o.mwrite, o.mbe);
    else n_pass++;
    n_chk++; if (miss_count !== 1) $display("FAIL rd_miss_cnt: got %0d want 1", miss_count); else n_pass++;
    h = model_access(1'b0, 32'h100);
    do_req(1'b0, 32'h100, '0, 4'h0, 0, 0, o);
    n_chk++; if (!o.got || o.lat !== 0 || o.hit !== 1'b1 || o.vcycles !== 0 || o.rdata !== 32'hDEADBEEF)
      $display("FAIL rd_hit: got=%b lat=%0d hit=%b memcyc=%0d data=%h want 1 0 1 0 deadbeef",
               o.got, o.lat, o.hit, o.vcycles, o.rdata);
    else n_pass++;
    n_chk++; if (hit_count !== 1) $display("FAIL rd_hit_cnt: got %0d want 1", hit_count); else n_pass++;
    last_rdata = 32'hDEADBEEF;
  endtask

  task automatic test_eviction();
    obs_t o;
    logic [31:0] seq [5] = '{32'h300, 32'h500, 32'h300, 32'h100, 32'h300};
    bit want [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      logic [31:0] d = mem_word(seq[i]);
      bit h = model_access(1'b0, seq[i]);
      do_req(1'b0, seq[i], '0, 4'h0, i % 2, 1, o);
      n_chk++; if (!o.got || o.hit !== want[i] || o.miss !== !want[i] || o.rdata !== d || h !== want[i])
        $display("FAIL evict_%0d: got=%b hit=%b miss=%b data=%h model=%b want hit=%b data=%h",
                 i, o.got, o.hit, o.miss, o.rdata, h, want[i], d);
      else n_pass++;
      last_rdata = d;
    end
  endtask

  task automatic test_write_hit();
    obs_t o;
    bit h;
    h = model_access(1'b1, 32'h100);
    do_req(1'b1, 32'h100, 32'h0000_1234, 4'b0011, 1, 0, o);
    mem_write(32'h100, 32'h0000_1234, 4'b0011);
    n_chk++; if (!o.got || o.hit !== 1'b1 || o.miss !== 1'b0 || o.rdata !== last_rdata)
      $display("FAIL wr_hit_resp: got=%b hit=%b miss=%b data=%h want 1 1 0 %h", o.got, o.hit, o.miss, o.rdata, last_rdata);
    else n_pass++;
    n_chk++; if (o.nreq !== 1 || o.mwrite !== 1'b1 || o.maddr !== 32'h100 || o.mbe !== 4'b0011 || o.mwdata !== 32'h1234)
      $display("FAIL wr_hit_mem: n=%0d wr=%b addr=%h be=%h data=%h want 1 1 100 3 00001234",
               o.nreq, o.mwrite, o.maddr, o.mbe, o.mwdata);
    else n_pass++;
    h = model_access(1'b0, 32'h100);
    do_req(1'b0, 32'h100, '0, 4'h0, 0, 0, o);
    n_chk++; if (!o.got || o.hit !== 1'b1 || o.nreq !== 0 || o.rdata !== 32'hDEAD1234)
      $display("FAIL wr_merge_read: got=%b hit=%b n=%0d data=%h want 1 1 0 dead1234", o.got, o.hit, o.nreq, o.rdata);
    else n_pass++;
    last_rdata = 32'hDEAD1234;
  endtask

  task automatic test_write_miss();
    obs_t o;
    bit h;
    int mc0 = exp_mc;
    h = model_access(1'b1, 32'h800);
    do_req(1'b1, 32'h800, 32'hCAFE_F00D, 4'hF, 0, 0, o);
    mem_write(32'h800, 32'hCAFE_F00D, 4'hF);
    n_chk++; if (!o.got || o.miss !== 1'b1 || o.hit !== 1'b0 || o.nreq !== 1 || o.maddr !== 32'h800 || o.mwrite !== 1'b1)
      $display("FAIL wr_miss: got=%b miss=%b hit=%b n=%0d addr=%h wr=%b", o.got, o.miss, o.hit, o.nreq, o.maddr, o.mwrite);
    else n_pass++;
    n_chk++; if (miss_count !== mc0 + 1) $display("FAIL wr_miss_cnt: got %0d want %0d", miss_count, mc0 + 1); else n_pass++;
    h = model_access(1'b0, 32'h800);
    do_req(1'b0, 32'h800, '0, 4'h0, 0, 0, o);
    n_chk++; if (!o.got || o.miss !== 1'b1 || o.nreq !== 1 || o.rdata !== 32'hCAFEF00D)
      $display("FAIL no_allocate: got=%b miss=%b n=%0d data=%h want 1 1 1 cafef00d", o.got, o.miss, o.nreq, o.rdata);
    else n_pass++;
    last_rdata = 32'hCAFEF00D;
  endtask

  task automatic test_backpressure();
    obs_t o;
    logic [31:0] d = mem_word(32'hA00);
    bit h = model_access(1'b0, 32'hA00);
    do_req(1'b0, 32'hA00, '0, 4'h0, 5, 2, o);
    n_chk++; if (o.vcycles !== 6 || o.unstable !== 1'b0 || o.ready_bad !== 1'b0 || o.extra !== 1'b0)
      $display("FAIL backpressure: memcyc=%0d unstable=%b ready=%b extra=%b want 6 0 0 0",
               o.vcycles, o.unstable, o.ready_bad, o.extra);
    else n_pass++;
    n_chk++; if (!o.got || o.miss !== 1'b1 || o.rdata !== d || o.maddr !== 32'hA00 || h)
      $display("FAIL backpressure_resp: got=%b miss=%b data=%h addr=%h want 1 1 %h a00", o.got, o.miss, o.rdata, o.maddr, d);
    else n_pass++;
    last_rdata = d;
  endtask

  task automatic test_flush();
    obs_t o;
    bit h;
    flush = 1'b1; #1;
    n_chk++; if (req_ready !== 1'b0) $display("FAIL flush_ready: got %b want 0", req_ready); else n_pass++;
    @(posedge clk); #1;
    flush = 1'b0;
    model_clear(1'b0);
    h = model_access(1'b0, 32'h100);
    do_req(1'b0, 32'h100, '0, 4'h0, 0, 0, o);
    n_chk++; if (!o.got || o.miss !== 1'b1 || o.nreq !== 1 || o.rdata !== mem_word(32'h100) || h)
      $display("FAIL flush_miss: got=%b miss=%b n=%0d data=%h", o.got, o.miss, o.nreq, o.rdata);
    else n_pass++;
    last_rdata = mem_word(32'h100);
  endtask

  task automatic test_reset_mid();
    obs_t o;
    bit h;
    bit saw = 1'b0;
    // Reset while the read request is still being presented.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'hE00;
    @(posedge clk); #1; req_valid = 1'b0;
    rst_n = 1'b0; #1;
    n_chk++; if (mem_req_valid !== 1'b0) $display("FAIL rst_rdreq_memv: got %b want 0", mem_req_valid); else n_pass++;
    @(posedge clk); #1; rst_n = 1'b1;
    // Reset while waiting for the read data.
    req_valid = 1'b1; req_addr = 32'hC00;
    @(posedge clk); #1; req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(posedge clk); #1; mem_req_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    n_chk++; if (mem_req_valid !== 1'b0 || resp_valid !== 1'b0 || hit_count !== 0 || miss_count !== 0)
      $display("FAIL rst_mid: memv=%b resp=%b hc=%0d mc=%0d want 0 0 0 0", mem_req_valid, resp_valid, hit_count, miss_count);
    else n_pass++;
    mem_resp_valid = 1'b1; mem_rdata = 32'h1111_2222;
    @(posedge clk); #1; mem_resp_valid = 1'b0;
    rst_n = 1'b1;
    model_clear(1'b1); exp_hc = 0; exp_mc = 0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid) saw = 1'b1;
      @(posedge clk); #1;
    end
    n_chk++; if (saw) $display("FAIL rst_no_resp: got resp_valid after reset want none"); else n_pass++;
    h = model_access(1'b0, 32'h100);
    do_req(1'b0, 32'h100, '0, 4'h0, 0, 1, o);
    n_chk++; if (!o.got || o.miss !== 1'b1 || miss_count !== 1 || h)
      $display("FAIL rst_then_miss: got=%b miss=%b mc=%0d want 1 1 1", o.got, o.miss, miss_count);
    else n_pass++;
    last_rdata = o.rdata;
  endtask

  task automatic test_random();
    obs_t o;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, wd, d;
      logic [3:0]  be;
      bit wr, h;
      if ($urandom_range(0, 24) == 0) begin
        flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
        model_clear(1'b0);
      end
      a  = ($urandom_range(0, 5) << 9) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      wr = ($urandom_range(0, 2) == 0);
      wd = $urandom;
      be = 4'($urandom);
      d  = mem_word(a);
      h  = model_access(wr, a);
      do_req(wr, a, wd, be, $urandom_range(0, 3), $urandom_range(0, 3), o);
      n_chk++; if (!o.got || o.hit !== h || o.miss !== !h)
        $display("FAIL rnd_%0d_hitmiss: got=%b hit=%b miss=%b want hit=%b addr=%h wr=%b", i, o.got, o.hit, o.miss, h, a, wr);
      else n_pass++;
      n_chk++; if (o.rdata !== (wr ? last_rdata : d))
        $display("FAIL rnd_%0d_data: got %h want %h addr=%h wr=%b", i, o.rdata, wr ? last_rdata : d, a, wr);
      else n_pass++;
      n_chk++; if (o.nreq !== ((wr || !h) ? 1 : 0) || o.unstable || o.ready_bad || o.extra)
        $display("FAIL rnd_%0d_memreq: n=%0d unstable=%b ready=%b extra=%b", i, o.nreq, o.unstable, o.ready_bad, o.extra);
      else n_pass++;
      if (wr || !h) begin
        n_chk++; if (o.maddr !== {a[31:2], 2'b00} || o.mwrite !== wr || o.mbe !== (wr ? be : 4'hF) || (wr && o.mwdata !== wd))
          $display("FAIL rnd_%0d_payload: addr=%h wr=%b be=%h data=%h want %h %b %h %h",
                   i, o.maddr, o.mwrite, o.mbe, o.mwdata, {a[31:2], 2'b00}, wr, wr ? be : 4'hF, wd);
        else n_pass++;
      end
      if (wr) mem_write(a, wd, be);
      else last_rdata = d;
    end
    n_chk++; if (hit_count !== exp_hc || miss_count !== exp_mc)
      $display("FAIL rnd_counters: got %0d/%0d want %0d/%0d", hit_count, miss_count, exp_hc, exp_mc);
    else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_miss_hit();
    test_eviction();
    test_write_hit();
    test_write_miss();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cache_assoc.md
Name: cache_assoc

Overview:
Parametrised N-way set-associative write-through data cache. It sits between the core's data-memory port and backing memory. Compared with the earlier direct-mapped single-cycle cache, it adds:
- configurable ways and sets
- valid/ready request handshake
- real miss refill from backing memory
- byte-enable writes
- round-robin replacement
- flush
- hit/miss statistics counters

Line size is one word.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, word width; BE_WIDTH = DATA_WIDTH/8
WAYS, 2, associativity, power of 2 >= 1 (1 = direct-mapped)
SETS, 128, number of sets, power of 2 >= 2
CNT_WIDTH, 32, width of statistics counters

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
flush  in  1  invalidate all lines (accepted only in IDLE)
req_valid  in  1  core request valid
req_ready  out  1  cache can accept request (high only in IDLE with flush low)
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored
req_wdata  in  DATA_WIDTH  write data
req_be  in  BE_WIDTH  byte enables for writes
resp_valid  out  1  one-cycle pulse: read data valid / write complete
resp_rdata  out  DATA_WIDTH  read data, held until next resp_valid
hit  out  1  one-cycle pulse with resp_valid when the lookup hit
miss  out  1  one-cycle pulse with resp_valid when the lookup missed
mem_req_valid  out  1  backing-memory request valid
mem_req_ready  in  1  backing memory accepts request
mem_req_write  out  1  memory write
mem_addr  out  ADDR_WIDTH  word-aligned address ([1:0] = 0)
mem_wdata  out  DATA_WIDTH  write data
mem_be  out  BE_WIDTH  byte enables; all ones for reads
mem_resp_valid  in  1  read data returned (reads only)
mem_rdata  in  DATA_WIDTH  returned read data
hit_count  out  CNT_WIDTH  saturating count of read hits
miss_count  out  CNT_WIDTH  saturating count of read and write misses

Behaviour:
- Address split: index = req_addr[2+log2(SETS)-1:2]; tag = remaining upper bits.
- Per-way storage: data, tag, valid. Per-set storage: round-robin victim pointer.
- Reset low: all valid = 0, pointers = 0, counters = 0, state = IDLE. All outputs 0 (req_ready = 1 once reset releases).
- Reset mid-transaction abandons the transaction: mem_req_valid drops immediately and no resp_valid is issued.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ.
- IDLE, flush high:
  - all valid cleared at the clock edge
  - req_ready = 0 that cycle
  - flush has priority over req_valid
- IDLE, request accepted (req_valid & req_ready): tag compare across all ways is combinational.
  - Read hit: next cycle resp_valid = 1, hit = 1, resp_rdata = way data, hit_count++. State stays IDLE (1-cycle latency, back-to-back hits allowed).
  - Read miss: latch address → RD_REQ. miss_count++.
  - Write: latch addr/wdata/be → WR_REQ. On a hit, merge enabled bytes into the hit way now. On a miss, no allocate, miss_count++.
- RD_REQ:
  - mem_req_valid = 1, mem_req_write = 0, mem_be = all ones.
  - Address stable until mem_req_ready; then → RD_WAIT.
- RD_WAIT: on mem_resp_valid:
  - victim = lowest-index invalid way, else pointer[set]
  - write data/tag, set valid
  - pointer[set] advances (mod WAYS) only when the pointer was used
  - next cycle resp_valid = 1, miss = 1, resp_rdata = mem_rdata; → IDLE
- WR_REQ:
  - mem_req_valid = 1, mem_req_write = 1, mem_wdata/mem_be = latched values
  - on mem_req_ready → IDLE; next cycle resp_valid = 1
  - hit/miss reflect the original lookup; resp_rdata unchanged
- mem_req_valid, once high, stays high with stable payload until handshake.
- flush outside IDLE is ignored.
- Counters saturate at all ones.
- A read hit never issues a memory request.
- Only one outstanding request at a time.

Test Plan:
1. Read 0x0000_0100 on empty cache, mem returns 0xDEADBEEF after 3 cycles → one mem read at 0x100; resp_valid, miss, resp_rdata=0xDEADBEEF, miss_count=1. Repeat read → resp one cycle after accept, hit=1, no mem_req_valid, hit_count=1.
2. WAYS=2: reads 0x100, 0x300, 0x500 (all index 0x40) → all miss; 0x500 evicts way 0 (0x100). Read 0x300 hits; read 0x100 misses.
3. After 0x100=0xDEADBEEF, write be=0011 data 0x0000_1234 → mem write addr 0x100 be 0011; then read 0x100 hits with 0xDEAD1234.
4. Write 0x800 (not cached) → mem write, miss pulse, miss_count+1; then read 0x800 misses (no allocate).
5. Hold mem_req_ready low 5 cycles during read miss → mem_req_valid/mem_addr stable, req_ready=0, no resp until handshake + mem_resp_valid.
6. Flush in IDLE, then read 0x100 → miss. Assert reset during RD_WAIT → mem_req_valid/resp_valid 0, counters 0; subsequent read 0x100 misses.
